semaforo_3ruas_ctrl: RTL and testbench
======================================

// Module: semaforo_3ruas_ctrl
// PURPOSE
//  Sequential controller for the 3-road intersection: timed green/yellow/all-red cycle.
//  Grants one road at a time using car-presence sensors A, B, C.
//  Round-robin arbitration between requesting roads; road A rests green when idle.
//  Successor of the combinational 3-road light decoder; drives the lamp outputs directly.
// PARAMETERS
//  CW        8   counter width (bits)
//  T_GMIN    8   minimum green time, clock cycles (>=1)
//  T_GMAX    32  maximum green time while another road waits (>=T_GMIN, <2**CW)
//  T_YEL     4   yellow time, cycles (>=1)
//  T_ALLRED  2   all-red clearance time, cycles (>=1)
// PORTS
//  clock    in   1  system clock, rising edge
//  reset_n  in   1  asynchronous active-low reset
//  ABC      in   3  car sensors: [2]=road A, [1]=road B, [0]=road C (1 = car waiting)
//  VDA,VDB,VDC  out 1 each  green lamp, roads A/B/C
//  AMA,AMB,AMC  out 1 each  yellow lamp, roads A/B/C
//  VMA,VMB,VMC  out 1 each  red lamp, roads A/B/C
//  road     out  2  road currently owning the light: 0=A, 1=B, 2=C
//  phase    out  2  0=GREEN, 1=YELLOW, 2=ALLRED
// BEHAVIOUR
//  - Single clock domain; ABC sampled on clock, treated as synchronous (bench drives it away from edges).
//  - Registers: phase, road, nxt (2b), cnt (CW bits).
//  - Outputs are a pure decode of the registers; no combinational path from ABC.
//  - Exactly one lamp per road is lit every cycle.
//  - Reset (reset_n=0, async): phase=GREEN, road=A, nxt=A, cnt=0.
//    => VDA=1, VMB=VMC=1, all other lamps 0; road=0, phase=0.
//  - Effective request: req = (ABC==3'b000) ? 3'b100 : ABC (idle demand goes to A).
//  - GREEN(r): road r green, others red; cnt increments each cycle, saturating at T_GMAX-1.
//    - other = req with bit r masked off.
//    - Leave GREEN when other!=0 AND either:
//      (cnt>=T_GMIN-1 and req[r]==0) or (cnt==T_GMAX-1).
//    - On leaving: nxt = first set bit of other in order r+1, r+2 (A->B->C->A).
//      phase=YELLOW, cnt=0.
//    - If other==0: stay green indefinitely.
//  - YELLOW: road r yellow (AM=1, VD=0, VM=0), others red.
//    - After T_YEL cycles (cnt==T_YEL-1): phase=ALLRED, cnt=0.
//  - ALLRED: all three red.
//    - After T_ALLRED cycles: phase=GREEN, road=nxt, cnt=0.
//  - ABC changes during YELLOW/ALLRED are ignored; nxt is frozen once chosen.
//    The newly granted road always gets at least T_GMIN green cycles.
//  - Green duration (cycles, incl. first): T_GMIN when the owner has left;
//    T_GMAX when the owner still has demand and another road waits.
//  - Reset asserted mid-cycle (any phase): immediate return to GREEN(A) without waiting for a clock edge.
//    No yellow is shown.
//  - phase/road encodings 3 are unreachable; if ever decoded, force the GREEN(A) lamp pattern
//    and next state GREEN(A).
// TESTING (defaults: T_GMIN=8, T_GMAX=32, T_YEL=4, T_ALLRED=2)
//  1 Idle: release reset, ABC=000 for 200 cycles -> VDA=1, VMB=VMC=1 every cycle; phase stays 0.
//  2 Single request: reset release with ABC=010.
//    -> A green 8 cycles, AMA 4 cycles, all red 2 cycles, then VDB=1 (road=1) and held while ABC=010.
//  3 Contention: ABC=110 from reset -> A green exactly 32 cycles, yellow 4, all-red 2, then B green.
//    B green 32 cycles, then A.
//  4 Round robin: ABC=111 held -> grant order A,B,C,A,B,C; each green 32 cycles.
//    Exactly 38 cycles between successive green starts.
//  5 Frozen choice: ABC=001 until YELLOW of A, then ABC=010 -> C still granted next.
//    C green 8 cycles, then B.
//  6 Async reset: assert reset_n=0 mid-YELLOW of road B between edges.
//    -> lamps switch to VDA/VMB/VMC before the next edge; normal sequence resumes after release.

Source files
------------

// File: rtl/semaforo_3ruas_ctrl.sv
// Timed traffic-light controller for a 3-road intersection (A, B, C).
// Decodes lamps from the registers only, so there is no path from ABC to the outputs.
// Grants one road at a time, round-robin; an idle intersection rests green on A.
// Ports: clock/reset_n (async active-low), ABC car sensors ([2]=A,[1]=B,[0]=C),
//        VDx/AMx/VMx green/yellow/red lamps per road, road (0=A,1=B,2=C),
//        phase (0=GREEN,1=YELLOW,2=ALLRED).
module semaforo_3ruas_ctrl #(
    parameter int CW       = 8,
    parameter int T_GMIN   = 8,
    parameter int T_GMAX   = 32,
    parameter int T_YEL    = 4,
    parameter int T_ALLRED = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] ABC,
    output logic       VDA,
    output logic       VDB,
    output logic       VDC,
    output logic       AMA,
    output logic       AMB,
    output logic       AMC,
    output logic       VMA,
    output logic       VMB,
    output logic       VMC,
    output logic [1:0] road,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } phase_t;

    localparam logic [CW-1:0] GMIN_M1 = CW'(T_GMIN - 1);
    localparam logic [CW-1:0] GMAX_M1 = CW'(T_GMAX - 1);
    localparam logic [CW-1:0] YEL_M1  = CW'(T_YEL - 1);
    localparam logic [CW-1:0] AR_M1   = CW'(T_ALLRED - 1);

    phase_t        phase_q;
    logic [1:0]    road_q;
    logic [1:0]    nxt_q;
    logic [CW-1:0] cnt_q;

    // Sensor bit belonging to a road index; index 3 maps to no road.
    function automatic logic [2:0] road_mask(input logic [1:0] r);
        case (r)
            2'd0:    road_mask = 3'b100;
            2'd1:    road_mask = 3'b010;
            2'd2:    road_mask = 3'b001;
            default: road_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] succ(input logic [1:0] r);
        case (r)
            2'd0:    succ = 2'd1;
            2'd1:    succ = 2'd2;
            default: succ = 2'd0;
        endcase
    endfunction

    logic [2:0] req;
    logic [2:0] other;
    logic       own_req;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] pick;
    logic       leave_green;
    logic       bad_state;

    always_comb begin
        // No cars anywhere counts as demand for A, so A rests green.
        req         = (ABC == 3'b000) ? 3'b100 : ABC;
        own_req     = |(req & road_mask(road_q));
        other       = req & ~road_mask(road_q);
        cand1       = succ(road_q);
        cand2       = succ(cand1);
        pick        = |(other & road_mask(cand1)) ? cand1 : cand2;
        leave_green = (other != 3'b000) &&
                      (((cnt_q >= GMIN_M1) && !own_req) || (cnt_q == GMAX_M1));
        bad_state   = (phase_q == phase_t'(2'd3)) || (road_q == 2'd3);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= GREEN;
            road_q  <= 2'd0;
            nxt_q   <= 2'd0;
            cnt_q   <= '0;
        end else if (bad_state) begin
            phase_q <= GREEN;
            road_q  <= 2'd0;
            nxt_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            case (phase_q)
                GREEN: begin
                    if (leave_green) begin
                        // Successor is chosen here and held through yellow/all-red.
                        phase_q <= YELLOW;
                        nxt_q   <= pick;
                        cnt_q   <= '0;
                    end else if (cnt_q != GMAX_M1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                YELLOW: begin
                    if (cnt_q == YEL_M1) begin
                        phase_q <= ALLRED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ALLRED: begin
                    if (cnt_q == AR_M1) begin
                        phase_q <= GREEN;
                        road_q  <= nxt_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    phase_q <= GREEN;
                    road_q  <= 2'd0;
                    nxt_q   <= 2'd0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Lamp decode: every road shows red unless it owns the light in GREEN/YELLOW.
    always_comb begin
        VDA = 1'b0; AMA = 1'b0; VMA = 1'b1;
        VDB = 1'b0; AMB = 1'b0; VMB = 1'b1;
        VDC = 1'b0; AMC = 1'b0; VMC = 1'b1;
        road  = road_q;
        phase = phase_q;
        if (bad_state) begin
            VDA   = 1'b1;
            VMA   = 1'b0;
            road  = 2'd0;
            phase = 2'd0;
        end else if (phase_q == GREEN) begin
            case (road_q)
                2'd0:    begin VDA = 1'b1; VMA = 1'b0; end
                2'd1:    begin VDB = 1'b1; VMB = 1'b0; end
                default: begin VDC = 1'b1; VMC = 1'b0; end
            endcase
        end else if (phase_q == YELLOW) begin
            case (road_q)
                2'd0:    begin AMA = 1'b1; VMA = 1'b0; end
                2'd1:    begin AMB = 1'b1; VMB = 1'b0; end
                default: begin AMC = 1'b1; VMC = 1'b0; end
            endcase
        end
    end

endmodule

// File: tb/tb_semaforo_3ruas_ctrl.sv
// Directed bench for the 3-road traffic-light controller, default timing
// (T_GMIN=8, T_GMAX=32, T_YEL=4, T_ALLRED=2). Expected lamp/phase/road
// sequences are built per scenario from hand-derived segment lengths.
module tb_semaforo_3ruas_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] ABC = 3'b000;
    logic       VDA, VDB, VDC, AMA, AMB, AMC, VMA, VMB, VMC;
    logic [1:0] road, phase;

    int n_checks = 0;
    int n_fail   = 0;

    int eph[$];
    int erd[$];

    semaforo_3ruas_ctrl dut (
        .clock  (clock),
        .reset_n(reset_n),
        .ABC    (ABC),
        .VDA    (VDA),
        .VDB    (VDB),
        .VDC    (VDC),
        .AMA    (AMA),
        .AMB    (AMB),
        .AMC    (AMC),
        .VMA    (VMA),
        .VMB    (VMB),
        .VMC    (VMC),
        .road   (road),
        .phase  (phase)
    );

    always #5 clock = ~clock;

    wire [12:0] obs = {VDA, AMA, VMA, VDB, AMB, VMB, VDC, AMC, VMC, phase, road};

    // Expected {lamps A,B,C as VD/AM/VM, phase, road} for a given state.
    function automatic logic [12:0] expv(input int ph, input int rd);
        logic [8:0] l;
        logic [1:0] p;
        logic [1:0] r;
        for (int i = 0; i < 3; i++) begin
            if (ph == 2 || i != rd) l[8-3*i -: 3] = 3'b001;
            else if (ph == 0)       l[8-3*i -: 3] = 3'b100;
            else                    l[8-3*i -: 3] = 3'b010;
        end
        p = ph[1:0];
        r = rd[1:0];
        return {l, p, r};
    endfunction

    task automatic add_seg(input int ph, input int rd, input int len);
        for (int k = 0; k < len; k++) begin
            eph.push_back(ph);
            erd.push_back(rd);
        end
    endtask

    // Holds reset over two falling edges, then releases on a falling edge.
    task automatic do_reset(input logic [2:0] abc);
        reset_n = 1'b0;
        ABC     = abc;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [12:0] e;
        reset_n = 1'b0;
        ABC     = 3'b111;
        @(negedge clock);
        #1;
        e = expv(0, 0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs, e);
        end
        ABC = 3'b011;
        @(negedge clock);
        #1;
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_abc_ignored: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_idle;
        logic [12:0] e;
        do_reset(3'b000);
        e = expv(0, 0);
        for (int k = 0; k < 200; k++) begin
            #1;
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL idle cyc %0d: got %b expected %b", k, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_single_request;
        logic [12:0] e;
        eph.delete(); erd.delete();
        add_seg(0, 0, 8); add_seg(1, 0, 4); add_seg(2, 0, 2); add_seg(0, 1, 20);
        do_reset(3'b010);
        for (int k = 0; k < eph.size(); k++) begin
            #1;
            e = expv(eph[k], erd[k]);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single_req cyc %0d: got %b expected %b", k, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_contention;
        logic [12:0] e;
        eph.delete(); erd.delete();
        add_seg(0, 0, 32); add_seg(1, 0, 4); add_seg(2, 0, 2);
        add_seg(0, 1, 32); add_seg(1, 1, 4); add_seg(2, 1, 2);
        add_seg(0, 0, 5);
        do_reset(3'b110);
        for (int k = 0; k < eph.size(); k++) begin
            #1;
            e = expv(eph[k], erd[k]);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL contention cyc %0d: got %b expected %b", k, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_round_robin;
        logic [12:0] e;
        eph.delete(); erd.delete();
        for (int g = 0; g < 6; g++) begin
            add_seg(0, g % 3, 32); add_seg(1, g % 3, 4); add_seg(2, g % 3, 2);
        end
        add_seg(0, 0, 3);
        do_reset(3'b111);
        for (int k = 0; k < eph.size(); k++) begin
            #1;
            e = expv(eph[k], erd[k]);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL round_robin cyc %0d: got %b expected %b", k, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_frozen_choice;
        logic [12:0] e;
        eph.delete(); erd.delete();
        add_seg(0, 0, 8); add_seg(1, 0, 4); add_seg(2, 0, 2);
        add_seg(0, 2, 8); add_seg(1, 2, 4); add_seg(2, 2, 2);
        add_seg(0, 1, 10);
        do_reset(3'b001);
        for (int k = 0; k < eph.size(); k++) begin
            #1;
            // Demand moves to B once A has already turned yellow.
            if (k == 8) ABC = 3'b010;
            e = expv(eph[k], erd[k]);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL frozen_choice cyc %0d: got %b expected %b", k, obs, e);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_async_reset;
        logic [12:0] e;
        eph.delete(); erd.delete();
        add_seg(0, 0, 8); add_seg(1, 0, 4); add_seg(2, 0, 2);
        add_seg(0, 1, 8); add_seg(1, 1, 2);
        do_reset(3'b010);
        for (int k = 0; k < eph.size(); k++) begin
            #1;
            // B's own demand drops as soon as it is granted, so it yields after T_GMIN.
            if (k == 14) ABC = 3'b100;
            e = expv(eph[k], erd[k]);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL async_pre cyc %0d: got %b expected %b", k, obs, e);
            end
            @(negedge clock);
        end
        // Now in the third yellow cycle of B; pull reset between edges.
        #2;
        reset_n = 1'b0;
        #1;
        e = expv(0, 0);
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_immediate: got %b expected %b", obs, e);
        end
        eph.delete(); erd.delete();
        add_seg(0, 0, 8); add_seg(1, 0, 4); add_seg(2, 0, 2); add_seg(0, 1, 4);
        @(negedge clock);
        do_reset(3'b010);
        for (int k = 0; k < eph.size(); k++) begin
            #1;
            e = expv(eph[k], erd[k]);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL async_resume cyc %0d: got %b expected %b", k, obs, e);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_request();
        test_contention();
        test_round_robin();
        test_frozen_choice();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
